spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  Frame/command controller for the SPI slave. It runs beside the 8-bit deserializer and on the same spi_clk.
//  - Counts bits and frames bytes, taking each byte as {byte_deser[6:0], pico} on the 8th edge.
//  - Decodes the command byte and drives the register-bank write/read port with address auto-increment.
//  - Serialises read data onto poci, MSB first.
// PARAMETERS
//  ADDR_W    7    register address width; taken from cmd[6:0] and wraps mod 2**ADDR_W
//  NUM_REGS  64   implemented registers; an address >= NUM_REGS is out of range
// PORTS
//  spi_clk      in   1       the block's only clock; free-running during and between frames
//  rst          in   1       synchronous, active-high reset
//  cs           in   1       chip select, active high; frame active while high
//  pico         in   1       serial data in (same bit the deserializer shifts)
//  byte_deser   in   8       deserializer shift-register contents
//  reg_addr     out  ADDR_W  register-bank address
//  reg_wr_en    out  1       single-cycle write strobe
//  reg_wr_data  out  8       write data
//  reg_rd_en    out  1       read strobe; reg_rd_data is sampled in the same cycle
//  reg_rd_data  in   8       register-bank read data; combinational from reg_addr
//  poci         out  1       serial data out
//  frame_err    out  1       sticky: a frame ended mid-byte, or an out-of-range access occurred
// BEHAVIOUR
//  Reset and clocking
//  - Reset is synchronous and active-high. On rst: state=IDLE, bit_cnt=0, addr_q=0, tx_sr=0.
//    All outputs are then 0: reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, poci, frame_err.
//  - All state changes happen on the spi_clk posedge; there is no other clock.
//  Framing
//  - cs low at any edge: state<=IDLE, bit_cnt<=0, no strobes.
//  - If cs is low at an edge while state!=IDLE and bit_cnt!=0, frame_err<=1.
//  - cs high: bit_cnt increments 0..7 and wraps to 0; byte_done = (bit_cnt==7).
//    The byte value at that edge is b = {byte_deser[6:0], pico}.
//  - States: IDLE, CMD, WDATA, RDATA.
//    - IDLE -> CMD on the first edge with cs=1. That edge is counted as bit 0.
//    - CMD, byte_done: addr_q<=b[6:0]. Go to WDATA if b[7]=1 (write), else RDATA.
//  Write path
//  - WDATA, byte_done: reg_wr_data<=b, reg_addr<=addr_q, reg_wr_en<=1 for exactly one cycle.
//    Then addr_q<=addr_q+1, wrapping.
//    Registered, so the strobe is visible in the cycle after the 8th edge.
//  Read path
//  - RDATA: reg_rd_en = (bit_cnt==0) and reg_addr = addr_q. On that edge tx_sr<=reg_rd_data.
//  - On edges with bit_cnt 1..7: tx_sr<=tx_sr<<1.
//  - poci = tx_sr[7], registered and launched on posedge. The master captures on negedge.
//    Zero dummy bytes: the first read byte follows the command byte directly.
//  - RDATA, byte_done: addr_q<=addr_q+1, wrapping.
//  Boundaries
//  - Out-of-range address (>= NUM_REGS): write suppressed (reg_wr_en stays 0), read loads 8'h00, frame_err<=1.
//  - Address wrap: 2**ADDR_W-1 -> 0 with no error by itself.
//  - cs falling mid-byte: the partial byte is discarded, no strobe, frame_err set.
//  - rst takes priority over cs and over everything else; rst mid-frame aborts the frame silently (no frame_err).
//  - frame_err clears only on rst.
// STRUCTURE
//  - Package psec6_spi_pkg:
//    - typedef enum logic [1:0] spi_state_t {IDLE, CMD, WDATA, RDATA};
//    - localparam CMD_WR_BIT=7; localparam BYTE_W=8.
//  - Sub-module spi_tx_shifter: 8-bit load/shift register driving poci. Inputs load, shift, din[7:0], rst.
//  - The FSM, bit counter and address counter stay in spi_reg_ctrl.
// TESTING
//  1. rst=1 for 2 edges -> all outputs 0, state IDLE; then cs=1 with no data -> no strobes.
//  2. Write frame, cs=1, bytes 0x85,0xA5,0x3C -> reg_wr_en pulses twice: (addr 5, 0xA5), then (addr 6, 0x3C).
//     frame_err=0.
//  3. Read frame: cmd 0x12 (addr 0x12) with bank[0x12]=0xC3, bank[0x13]=0x5A, 16 bits clocked.
//     -> poci shows 1100_0011 then 0101_1010; reg_rd_en pulses at bit 0 of each data byte.
//  4. Write cmd 0xFF (addr 127) then 2 data bytes, NUM_REGS=64.
//     -> no reg_wr_en, frame_err=1; address goes 127->0 with no extra error.
//  5. cs dropped after 3 bits of a data byte -> no strobe, frame_err=1.
//     Next frame (cmd 0x81, data 0x11) -> correct write to addr 1.
//  6. rst asserted at bit 4 of a write data byte -> no strobe, frame_err=0; the next edge with cs=1 is bit 0 of CMD.

Source files
------------

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI slave frame/command controller.
package psec6_spi_pkg;
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} spi_state_t;
    localparam int CMD_WR_BIT = 7;
    localparam int BYTE_W     = 8;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register-bank port: the controller is the master, the bank is the slave.
interface spi_reg_ctrl_if #(parameter int ADDR_W = 7);
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en;
    logic [7:0]        reg_wr_data;
    logic              reg_rd_en;
    logic [7:0]        reg_rd_data;

    modport master (output reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, input reg_rd_data);
    modport slave  (input reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, output reg_rd_data);
endinterface

// File: rtl/spi_reg_ctrl_tx_shifter.sv
// 8-bit load/shift register; MSB drives poci straight from the flop.
module spi_tx_shifter
    import psec6_spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] din,
    output logic              dout
);
    logic [BYTE_W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load)
            sr_d = din;
        else if (shift)
            sr_d = {sr_q[BYTE_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign dout = sr_q[BYTE_W-1];
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave frame controller: bit/byte framing, command decode, register
// write/read with address auto-increment, and read-data serialisation.
module spi_reg_ctrl
    import psec6_spi_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 64
)(
    input  logic              spi_clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              pico,
    input  logic [BYTE_W-1:0] byte_deser,
    spi_reg_ctrl_if.master    bus,
    output logic              poci,
    output logic              frame_err
);
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    spi_state_t        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              err_q, err_d;

    logic [BYTE_W-1:0] rx_byte;
    logic              byte_done, addr_ok, rd_load, rd_shift;
    logic              unused_deser_msb;

    // On the 8th edge the deserializer has not yet absorbed the current pico bit.
    assign rx_byte          = {byte_deser[BYTE_W-2:0], pico};
    assign unused_deser_msb = byte_deser[BYTE_W-1];
    assign byte_done        = (bit_cnt_q == 3'd7);
    assign addr_ok          = ({1'b0, addr_q} < NUM_REGS_W);
    assign rd_load          = cs && (state_q == RDATA) && (bit_cnt_q == 3'd0);
    assign rd_shift         = cs && (state_q == RDATA) && (bit_cnt_q != 3'd0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        err_d     = err_q;
        if (!cs) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            if (state_q != IDLE && bit_cnt_q != 3'd0)
                err_d = 1'b1;
        end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                IDLE: state_d = CMD;
                CMD: if (byte_done) begin
                    addr_d  = rx_byte[ADDR_W-1:0];
                    state_d = rx_byte[CMD_WR_BIT] ? WDATA : RDATA;
                end
                WDATA: if (byte_done) begin
                    if (addr_ok) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_byte;
                    end else begin
                        err_d = 1'b1;
                    end
                    addr_d = addr_q + ADDR_W'(1);
                end
                RDATA: begin
                    if (bit_cnt_q == 3'd0 && !addr_ok)
                        err_d = 1'b1;
                    if (byte_done)
                        addr_d = addr_q + ADDR_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
        end
    end

    // Reads present the live address combinationally; writes present the latched one.
    assign bus.reg_addr    = (state_q == RDATA) ? addr_q : wr_addr_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.reg_rd_en   = rd_load;
    assign frame_err       = err_q;

    spi_tx_shifter u_tx (
        .clk   (spi_clk),
        .rst   (rst),
        .load  (rd_load),
        .shift (rd_shift),
        .din   (addr_ok ? bus.reg_rd_data : '0),
        .dout  (poci)
    );
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: drives SPI frames bit by bit, models a 64-entry bank.
module tb_spi_reg_ctrl;
    logic       spi_clk = 1'b0;
    logic       rst = 1'b1, cs = 1'b0, pico = 1'b0;
    logic [7:0] byte_deser = 8'h00;
    logic       poci, frame_err;

    always #5 spi_clk = ~spi_clk;

    spi_reg_ctrl_if #(.ADDR_W(7)) bus ();

    spi_reg_ctrl #(.ADDR_W(7), .NUM_REGS(64)) dut (
        .spi_clk    (spi_clk),
        .rst        (rst),
        .cs         (cs),
        .pico       (pico),
        .byte_deser (byte_deser),
        .bus        (bus.master),
        .poci       (poci),
        .frame_err  (frame_err)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 73 + 29);
    endfunction

    // Environment: deserializer and register bank.
    logic [7:0] bank [64];
    always @(posedge spi_clk) byte_deser <= {byte_deser[6:0], pico};
    always @(posedge spi_clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) bank[i] <= init_val(i);
        end else if (bus.reg_wr_en && bus.reg_addr < 7'd64) begin
            bank[bus.reg_addr[5:0]] <= bus.reg_wr_data;
        end
    end
    assign bus.reg_rd_data = (bus.reg_addr < 7'd64) ? bank[bus.reg_addr[5:0]] : 8'hEE;

    // Reference model state.
    logic [7:0]  mdl [64];
    logic        m_err;
    logic [7:0]  dq [$];
    logic [14:0] wq [$];
    int total = 0, bad = 0;

    task automatic tick(input logic c, input logic p);
        @(negedge spi_clk);
        cs = c;
        pico = p;
        @(posedge spi_clk);
        #1;
        if (bus.reg_wr_en) wq.push_back({bus.reg_addr, bus.reg_wr_data});
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) tick(1'b1, v[i]);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
        wq.delete();
        m_err = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = init_val(i);
    endtask

    task automatic write_frame(input logic [7:0] cmd);
        logic [6:0]  a;
        logic [14:0] exp_q [$];
        a = cmd[6:0];
        send_byte(cmd);
        foreach (dq[j]) begin
            if (a < 7'd64) begin
                exp_q.push_back({a, dq[j]});
                mdl[a[5:0]] = dq[j];
            end else begin
                m_err = 1'b1;
            end
            send_byte(dq[j]);
            a = a + 7'd1;
        end
        tick(1'b0, 1'b0);
        total++;
        if (wq.size() != exp_q.size()) begin
            bad++;
            $display("FAIL wr_count cmd=%h got=%0d exp=%0d", cmd, wq.size(), exp_q.size());
        end else begin
            foreach (exp_q[j]) begin
                total++;
                if (wq[j] !== exp_q[j]) begin
                    bad++;
                    $display("FAIL wr_entry%0d cmd=%h got addr=%h data=%h exp addr=%h data=%h",
                             j, cmd, wq[j][14:8], wq[j][7:0], exp_q[j][14:8], exp_q[j][7:0]);
                end
            end
        end
        total++;
        if (frame_err !== m_err) begin
            bad++;
            $display("FAIL wr_frame_err cmd=%h got=%b exp=%b", cmd, frame_err, m_err);
        end
        wq.delete();
    endtask

    task automatic read_frame(input logic [7:0] cmd, input int n);
        logic [6:0] a;
        logic [7:0] got, expb;
        logic       en_ok;
        a = cmd[6:0];
        send_byte(cmd);
        total++;
        if (bus.reg_rd_en !== 1'b1 || bus.reg_addr !== a) begin
            bad++;
            $display("FAIL rd_first cmd=%h got en=%b addr=%h exp en=1 addr=%h", cmd, bus.reg_rd_en, bus.reg_addr, a);
        end
        for (int j = 0; j < n; j++) begin
            expb = (a < 7'd64) ? mdl[a[5:0]] : 8'h00;
            if (a >= 7'd64) m_err = 1'b1;
            got = 8'h00;
            en_ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick(1'b1, 1'($urandom));
                got = {got[6:0], poci};
                if (k < 7 && bus.reg_rd_en !== 1'b0) en_ok = 1'b0;
            end
            a = a + 7'd1;
            total++;
            if (got !== expb) begin
                bad++;
                $display("FAIL rd_data%0d cmd=%h got=%h exp=%h", j, cmd, got, expb);
            end
            total++;
            if (!en_ok || bus.reg_rd_en !== 1'b1 || bus.reg_addr !== a) begin
                bad++;
                $display("FAIL rd_strobe%0d cmd=%h got en_ok=%b en=%b addr=%h exp addr=%h",
                         j, cmd, en_ok, bus.reg_rd_en, bus.reg_addr, a);
            end
        end
        tick(1'b0, 1'b0);
        total++;
        if (frame_err !== m_err || wq.size() != 0) begin
            bad++;
            $display("FAIL rd_frame_end cmd=%h got err=%b writes=%0d exp err=%b writes=0",
                     cmd, frame_err, wq.size(), m_err);
        end
        wq.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        total++;
        if ({bus.reg_addr, bus.reg_wr_en, bus.reg_wr_data, bus.reg_rd_en} !== 17'h0) begin
            bad++;
            $display("FAIL reset_bus got addr=%h we=%b wd=%h re=%b exp all 0",
                     bus.reg_addr, bus.reg_wr_en, bus.reg_wr_data, bus.reg_rd_en);
        end
        total++;
        if ({poci, frame_err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_pins got poci=%b err=%b exp 0 0", poci, frame_err);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'($urandom));
            total++;
            if (bus.reg_wr_en !== 1'b0 || bus.reg_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL idle_cmd_strobe bit%0d got we=%b re=%b exp 0 0", i, bus.reg_wr_en, bus.reg_rd_en);
            end
        end
        do_reset();
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort_err got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_write;
        do_reset();
        dq = '{};
        dq.push_back(8'hA5);
        dq.push_back(8'h3C);
        write_frame(8'h85);
    endtask

    task automatic test_read;
        do_reset();
        dq = '{};
        dq.push_back(8'hC3);
        dq.push_back(8'h5A);
        write_frame(8'h92);
        read_frame(8'h12, 2);
    endtask

    task automatic test_oor_wrap;
        do_reset();
        dq = '{};
        dq.push_back(8'($urandom));
        dq.push_back(8'($urandom));
        write_frame(8'hFF);
        read_frame(8'h3F, 2);
        read_frame(8'h7F, 2);
    endtask

    task automatic test_cs_abort;
        do_reset();
        send_byte(8'h8A);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        total++;
        if (wq.size() != 0 || frame_err !== 1'b1) begin
            bad++;
            $display("FAIL cs_abort got writes=%0d err=%b exp writes=0 err=1", wq.size(), frame_err);
        end
        m_err = 1'b1;
        wq.delete();
        dq = '{};
        dq.push_back(8'h11);
        write_frame(8'h81);
    endtask

    task automatic test_rst_mid;
        do_reset();
        send_byte(8'h90);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        rst = 1'b0;
        total++;
        if (wq.size() != 0 || bus.reg_wr_en !== 1'b0 || frame_err !== 1'b0 || bus.reg_addr !== 7'h00) begin
            bad++;
            $display("FAIL rst_mid got writes=%0d we=%b err=%b addr=%h exp 0 0 0 00",
                     wq.size(), bus.reg_wr_en, frame_err, bus.reg_addr);
        end
        wq.delete();
        m_err = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = init_val(i);
        dq = '{};
        dq.push_back(8'($urandom));
        write_frame(8'h83);
    endtask

    task automatic test_random;
        logic [7:0] cmd;
        int n;
        do_reset();
        for (int f = 0; f < 16; f++) begin
            cmd = 8'($urandom);
            n = $urandom_range(1, 4);
            if (cmd[7]) begin
                dq = '{};
                for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
                write_frame(cmd);
            end else begin
                read_frame(cmd, n);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] a;
        for (int r = 0; r < 3; r++) begin
            a = 7'($urandom_range(0, 63));
            dq = '{};
            for (int j = 0; j < 3; j++) dq.push_back(8'($urandom));
            write_frame({1'b1, a});
            read_frame({1'b0, a}, 3);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_oor_wrap();
        test_cs_abort();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
